// File: rtl/cache_arbiter.sv
// cache_arbiter
// Shares the single burst-memory port between the instruction cache and the
// data cache. One cache-line transaction is in flight at a time. The granted
// client's address/data/op are captured on grant and held until memory
// answers, and the memory response is steered only to the granted client.
//
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   i_mem_read, i_mem_address     icache line-fill request
//   i_mem_rdata, i_mem_resp       icache response (data is shared, resp is qualified)
//   d_mem_read, d_mem_write       dcache fill / write-back request
//   d_mem_address, d_mem_wdata    dcache address and write-back line
//   d_mem_rdata, d_mem_resp       dcache response
//   mem_read, mem_write           strobes toward physical memory
//   mem_address, mem_wdata        registered address/line toward physical memory
//   mem_rdata, mem_resp           response from physical memory

module cache_arbiter #(
    parameter int LINE_W       = 256,
    parameter int ADDR_W       = 32,
    parameter int MAX_D_CONSEC = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,

    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int CNT_W = $clog2(MAX_D_CONSEC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_CONSEC);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RELEASE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  dcnt_q, dcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              opWrite_q, opWrite_d;

    logic dReq;
    logic grantD;
    logic grantI;

    // Grant decision. The dcache normally wins, but once it has taken
    // MAX_D_CONSEC grants in a row while the icache was waiting, the icache
    // is forced in. With the icache idle the dcache always wins.
    always_comb begin
        dReq   = d_mem_read | d_mem_write;
        grantD = dReq & ((dcnt_q < CNT_MAX) | ~i_mem_read);
        grantI = ~grantD & i_mem_read;
    end

    // State register plus the transaction capture registers. Address, data
    // and op are only reloaded from IDLE, so they stay frozen for the whole
    // transaction even if the client changes its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            opWrite_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            opWrite_q <= opWrite_d;
        end
    end

    // Next-state, strobe and response decode. Strobes and responses are
    // decoded from the state register so an async reset drops them at once,
    // and a mem_resp arriving outside SERVE_x has no effect.
    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        opWrite_d  = opWrite_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_mem_resp = 1'b0;
        d_mem_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (grantD) begin
                    state_d   = SERVE_D;
                    addr_d    = d_mem_address;
                    wdata_d   = d_mem_wdata;
                    // A write-back takes priority if both dcache strobes are up.
                    opWrite_d = d_mem_write;
                    if (i_mem_read) begin
                        dcnt_d = (dcnt_q == CNT_MAX) ? dcnt_q : dcnt_q + CNT_W'(1);
                    end else begin
                        dcnt_d = '0;
                    end
                end else if (grantI) begin
                    state_d   = SERVE_I;
                    addr_d    = i_mem_address;
                    opWrite_d = 1'b0;
                    dcnt_d    = '0;
                end
            end
            SERVE_I: begin
                mem_read   = 1'b1;
                i_mem_resp = mem_resp;
                if (mem_resp) begin
                    state_d = RELEASE;
                end
            end
            SERVE_D: begin
                mem_read   = ~opWrite_q;
                mem_write  = opWrite_q;
                d_mem_resp = mem_resp;
                if (mem_resp) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // One dead cycle so the client can drop its request before
                // the arbiter looks at it again.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data goes to both clients unqualified; each samples it on its resp.
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
// Self-checking bench for cache_arbiter. Each scenario task drives the
// clients and the memory side by hand, pushes the transaction it expects the
// arbiter to issue into a scoreboard queue, and pops/compares when the
// arbiter raises a memory strobe. A small fairness model predicts the grant
// order in the starvation scenario.

module tb_cache_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
    localparam int MAX_D  = 4;

    logic              clk;
    logic              rst;
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_address;
    logic [LINE_W-1:0] i_mem_rdata;
    logic              i_mem_resp;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_address;
    logic [LINE_W-1:0] d_mem_wdata;
    logic [LINE_W-1:0] d_mem_rdata;
    logic              d_mem_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    typedef struct {
        logic              isD;
        logic              isWrite;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } exp_t;

    exp_t expQ[$];
    int   checks;
    int   failures;
    int   modelDcnt;

    cache_arbiter #(
        .LINE_W(LINE_W),
        .ADDR_W(ADDR_W),
        .MAX_D_CONSEC(MAX_D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_mem_read(i_mem_read),
        .i_mem_address(i_mem_address),
        .i_mem_rdata(i_mem_rdata),
        .i_mem_resp(i_mem_resp),
        .d_mem_read(d_mem_read),
        .d_mem_write(d_mem_write),
        .d_mem_address(d_mem_address),
        .d_mem_wdata(d_mem_wdata),
        .d_mem_rdata(d_mem_rdata),
        .d_mem_resp(d_mem_resp),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_resp(mem_resp)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Put every input in a quiet state and pulse reset; returns at a negedge
    // with reset just released.
    task automatic reset_dut();
        rst           = 1'b1;
        i_mem_read    = 1'b0;
        i_mem_address = '0;
        d_mem_read    = 1'b0;
        d_mem_write   = 1'b0;
        d_mem_address = '0;
        d_mem_wdata   = '0;
        mem_rdata     = '0;
        mem_resp      = 1'b0;
        modelDcnt     = 0;
        expQ.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Step negedges until a memory strobe shows up, with a cycle budget.
    task automatic waitStrobe(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (mem_read || mem_write) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Reset holds everything at zero even with a pending icache request;
    // release lets the icache in on the next edge.
    task automatic test_reset();
        exp_t e;
        exp_t got;
        reset_dut();
        rst           = 1'b1;
        i_mem_read    = 1'b1;
        i_mem_address = 32'h40;
        @(negedge clk);
        checks++; if (mem_read !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_read actual=%0b expected=0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_write actual=%0b expected=0", mem_write); end
        checks++; if (mem_address !== '0) begin failures++; $display("[TB] FAIL reset_mem_address actual=%h expected=0", mem_address); end
        checks++; if (mem_wdata !== '0) begin failures++; $display("[TB] FAIL reset_mem_wdata actual=%h expected=0", mem_wdata); end
        checks++; if ({i_mem_resp, d_mem_resp} !== 2'b00) begin failures++; $display("[TB] FAIL reset_resps actual=%b expected=00", {i_mem_resp, d_mem_resp}); end
        e.isD = 1'b0; e.isWrite = 1'b0; e.addr = 32'h40; e.wdata = '0;
        expQ.push_back(e);
        rst = 1'b0;
        @(negedge clk);
        got = expQ.pop_front();
        checks++; if (mem_read !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_read actual=%0b expected=1", mem_read); end
        checks++; if (mem_address !== got.addr) begin failures++; $display("[TB] FAIL reset_release_addr actual=%h expected=%h", mem_address, got.addr); end
    endtask

    // Plain icache fill with a 4-cycle memory latency.
    task automatic test_icache_fill();
        exp_t e;
        exp_t got;
        bit   seen;
        reset_dut();
        i_mem_read    = 1'b1;
        i_mem_address = 32'h60;
        e.isD = 1'b0; e.isWrite = 1'b0; e.addr = 32'h60; e.wdata = '0;
        expQ.push_back(e);
        waitStrobe(seen);
        checks++; if (!seen) begin failures++; $display("[TB] FAIL ifill_grant actual=timeout expected=strobe"); end
        got = expQ.pop_front();
        checks++; if ({mem_read, mem_write} !== 2'b10) begin failures++; $display("[TB] FAIL ifill_strobes actual=%b expected=10", {mem_read, mem_write}); end
        checks++; if (mem_address !== got.addr) begin failures++; $display("[TB] FAIL ifill_addr actual=%h expected=%h", mem_address, got.addr); end
        repeat (3) @(negedge clk);
        checks++; if (i_mem_resp !== 1'b0) begin failures++; $display("[TB] FAIL ifill_early_resp actual=%0b expected=0", i_mem_resp); end
        mem_rdata = {8{32'hDEADBEEF}};
        mem_resp  = 1'b1;
        #1;
        checks++; if (i_mem_resp !== 1'b1) begin failures++; $display("[TB] FAIL ifill_resp actual=%0b expected=1", i_mem_resp); end
        checks++; if (i_mem_rdata !== {8{32'hDEADBEEF}}) begin failures++; $display("[TB] FAIL ifill_rdata actual=%h expected=%h", i_mem_rdata, {8{32'hDEADBEEF}}); end
        checks++; if (d_mem_resp !== 1'b0) begin failures++; $display("[TB] FAIL ifill_d_resp actual=%0b expected=0", d_mem_resp); end
        @(negedge clk);
        mem_resp   = 1'b0;
        i_mem_read = 1'b0;
        #1;
        checks++; if ({mem_read, i_mem_resp} !== 2'b00) begin failures++; $display("[TB] FAIL ifill_release actual=%b expected=00", {mem_read, i_mem_resp}); end
        @(negedge clk);
        @(negedge clk);
        checks++; if ({mem_read, mem_write} !== 2'b00) begin failures++; $display("[TB] FAIL ifill_idle actual=%b expected=00", {mem_read, mem_write}); end
    endtask

    // Both caches ask at once: the dcache write-back goes first, and the
    // icache gets the port two edges after the dcache response edge.
    task automatic test_simultaneous();
        exp_t e;
        exp_t got;
        reset_dut();
        i_mem_read    = 1'b1;
        i_mem_address = 32'h100;
        d_mem_write   = 1'b1;
        d_mem_address = 32'h80;
        d_mem_wdata   = {32{8'hA5}};
        e.isD = 1'b1; e.isWrite = 1'b1; e.addr = 32'h80;  e.wdata = {32{8'hA5}};
        expQ.push_back(e);
        e.isD = 1'b0; e.isWrite = 1'b0; e.addr = 32'h100; e.wdata = '0;
        expQ.push_back(e);
        @(negedge clk);
        got = expQ.pop_front();
        checks++; if ({mem_read, mem_write} !== 2'b01) begin failures++; $display("[TB] FAIL simul_d_strobes actual=%b expected=01", {mem_read, mem_write}); end
        checks++; if (mem_address !== got.addr) begin failures++; $display("[TB] FAIL simul_d_addr actual=%h expected=%h", mem_address, got.addr); end
        checks++; if (mem_wdata !== got.wdata) begin failures++; $display("[TB] FAIL simul_d_wdata actual=%h expected=%h", mem_wdata, got.wdata); end
        @(negedge clk);
        mem_resp = 1'b1;
        #1;
        checks++; if ({i_mem_resp, d_mem_resp} !== 2'b01) begin failures++; $display("[TB] FAIL simul_d_resp actual=%b expected=01", {i_mem_resp, d_mem_resp}); end
        @(negedge clk);
        mem_resp    = 1'b0;
        d_mem_write = 1'b0;
        checks++; if ({mem_read, mem_write} !== 2'b00) begin failures++; $display("[TB] FAIL simul_release actual=%b expected=00", {mem_read, mem_write}); end
        @(negedge clk);
        checks++; if ({mem_read, mem_write} !== 2'b00) begin failures++; $display("[TB] FAIL simul_idle actual=%b expected=00", {mem_read, mem_write}); end
        @(negedge clk);
        got = expQ.pop_front();
        checks++; if ({mem_read, mem_write} !== 2'b10) begin failures++; $display("[TB] FAIL simul_i_strobes actual=%b expected=10", {mem_read, mem_write}); end
        checks++; if (mem_address !== got.addr) begin failures++; $display("[TB] FAIL simul_i_addr actual=%h expected=%h", mem_address, got.addr); end
        mem_resp = 1'b1;
        #1;
        checks++; if ({i_mem_resp, d_mem_resp} !== 2'b10) begin failures++; $display("[TB] FAIL simul_i_resp actual=%b expected=10", {i_mem_resp, d_mem_resp}); end
        @(negedge clk);
        mem_resp   = 1'b0;
        i_mem_read = 1'b0;
    endtask

    // Icache stays pending while the dcache keeps asking. A fairness model
    // predicts each grant; two rounds show the counter clears after the
    // forced icache grant.
    task automatic test_starvation();
        exp_t e;
        exp_t got;
        bit   seen;
        bit   iReq;
        bit   dReq;
        reset_dut();
        i_mem_read    = 1'b1;
        i_mem_address = 32'h200;
        d_mem_read    = 1'b1;
        d_mem_address = 32'h1000;
        for (int t = 0; t < 10; t++) begin
            iReq = i_mem_read;
            dReq = d_mem_read | d_mem_write;
            e.isWrite = 1'b0;
            e.wdata   = '0;
            if (dReq && (modelDcnt < MAX_D || !iReq)) begin
                e.isD = 1'b1;
                e.addr = d_mem_address;
                modelDcnt = iReq ? ((modelDcnt < MAX_D) ? modelDcnt + 1 : MAX_D) : 0;
            end else begin
                e.isD = 1'b0;
                e.addr = i_mem_address;
                modelDcnt = 0;
            end
            expQ.push_back(e);
            waitStrobe(seen);
            checks++; if (!seen) begin failures++; $display("[TB] FAIL starve_grant_%0d actual=timeout expected=strobe", t); end
            got = expQ.pop_front();
            checks++; if (mem_address !== got.addr) begin failures++; $display("[TB] FAIL starve_addr_%0d actual=%h expected=%h", t, mem_address, got.addr); end
            repeat (2) @(negedge clk);
            mem_resp = 1'b1;
            #1;
            checks++; if ({i_mem_resp, d_mem_resp} !== (got.isD ? 2'b01 : 2'b10)) begin failures++; $display("[TB] FAIL starve_resp_%0d actual=%b expected=%b", t, {i_mem_resp, d_mem_resp}, (got.isD ? 2'b01 : 2'b10)); end
            @(negedge clk);
            mem_resp = 1'b0;
            if (got.isD) begin
                d_mem_address = d_mem_address + 32'h20;
            end else begin
                i_mem_address = i_mem_address + 32'h40;
            end
        end
        i_mem_read = 1'b0;
        d_mem_read = 1'b0;
    endtask

    // Reset in the middle of a write-back kills the strobe within the same
    // cycle, and a late memory response is ignored.
    task automatic test_reset_mid();
        bit seen;
        reset_dut();
        d_mem_write   = 1'b1;
        d_mem_address = 32'h300;
        d_mem_wdata   = {8{32'h12345678}};
        waitStrobe(seen);
        checks++; if (!(seen && mem_write === 1'b1)) begin failures++; $display("[TB] FAIL rmid_write_up actual=%0b expected=1", mem_write); end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({mem_read, mem_write} !== 2'b00) begin failures++; $display("[TB] FAIL rmid_strobe_drop actual=%b expected=00", {mem_read, mem_write}); end
        checks++; if (mem_address !== '0) begin failures++; $display("[TB] FAIL rmid_addr_clear actual=%h expected=0", mem_address); end
        @(negedge clk);
        d_mem_write = 1'b0;
        rst         = 1'b0;
        @(negedge clk);
        mem_resp = 1'b1;
        #1;
        checks++; if ({i_mem_resp, d_mem_resp} !== 2'b00) begin failures++; $display("[TB] FAIL rmid_late_resp actual=%b expected=00", {i_mem_resp, d_mem_resp}); end
        @(negedge clk);
        mem_resp = 1'b0;
        checks++; if ({mem_read, mem_write} !== 2'b00) begin failures++; $display("[TB] FAIL rmid_after actual=%b expected=00", {mem_read, mem_write}); end
    endtask

    // Client inputs that change during SERVE_D must not leak to memory.
    task automatic test_stale_input();
        exp_t e;
        exp_t got;
        bit   seen;
        reset_dut();
        d_mem_read    = 1'b1;
        d_mem_address = 32'h400;
        d_mem_wdata   = {64{4'h3}};
        e.isD = 1'b1; e.isWrite = 1'b0; e.addr = 32'h400; e.wdata = {64{4'h3}};
        expQ.push_back(e);
        waitStrobe(seen);
        checks++; if (!seen) begin failures++; $display("[TB] FAIL stale_grant actual=timeout expected=strobe"); end
        got = expQ.pop_front();
        d_mem_address = 32'h500;
        d_mem_wdata   = {64{4'hC}};
        d_mem_write   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (mem_address !== got.addr) begin failures++; $display("[TB] FAIL stale_addr_%0d actual=%h expected=%h", k, mem_address, got.addr); end
            checks++; if ({mem_read, mem_write} !== 2'b10) begin failures++; $display("[TB] FAIL stale_op_%0d actual=%b expected=10", k, {mem_read, mem_write}); end
        end
        checks++; if (mem_wdata !== got.wdata) begin failures++; $display("[TB] FAIL stale_wdata actual=%h expected=%h", mem_wdata, got.wdata); end
        mem_resp = 1'b1;
        #1;
        checks++; if (d_mem_resp !== 1'b1) begin failures++; $display("[TB] FAIL stale_resp actual=%0b expected=1", d_mem_resp); end
        @(negedge clk);
        mem_resp    = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        checks   = 0;
        failures = 0;
        $display("[TB] starting cache_arbiter bench");
        test_reset();
        test_icache_fill();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_stale_input();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates between the instruction cache and the data cache for the single burst-memory port at the top of the mp4 core. It accepts one 256-bit cache-line request at a time from either client, forwards it to physical memory, and returns the response only to the granted client. It sits directly downstream of both caches and directly upstream of the `mem_*` pins driven by the testbench memory model.

## Interface
- `LINE_W`, 256: cache-line width in bits.
- `ADDR_W`, 32: address width.
- `MAX_D_CONSEC`, 4: consecutive dcache grants allowed while an icache request waits, before icache is forced.

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_mem_read`  in  1  icache line-fill request.
- `i_mem_address`  in  ADDR_W  icache line address.
- `i_mem_rdata`  out  LINE_W  line data to icache.
- `i_mem_resp`  out  1  icache transaction complete.
- `d_mem_read`  in  1  dcache line-fill request.
- `d_mem_write`  in  1  dcache write-back request.
- `d_mem_address`  in  ADDR_W  dcache line address.
- `d_mem_wdata`  in  LINE_W  write-back data.
- `d_mem_rdata`  out  LINE_W  line data to dcache.
- `d_mem_resp`  out  1  dcache transaction complete.
- `mem_read`  out  1  memory read.
- `mem_write`  out  1  memory write.
- `mem_address`  out  ADDR_W  memory address, registered.
- `mem_wdata`  out  LINE_W  memory write data, registered.
- `mem_rdata`  in  LINE_W  memory read data.
- `mem_resp`  in  1  memory transaction complete.

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE. Reset state is IDLE.
- **IDLE:** no `mem_*` strobes. On a clock edge with any request, the arbiter grants as follows:
  - Grant dcache if `d_mem_read|d_mem_write` and `dcnt < MAX_D_CONSEC`, or if icache is idle.
  - Otherwise grant icache.
  - On grant, latch `mem_address` and `mem_wdata` (dcache only) and latch the op. `d_mem_write` wins if both dcache strobes are high.
- **SERVE_I:** `mem_read=1`.
- **SERVE_D:** `mem_read` or `mem_write` per the latched op.
- Exit from SERVE_x: go to RELEASE on the edge where `mem_resp=1`.
- **RELEASE:** one cycle, no strobes, then IDLE. This gives the client one cycle to drop its request so a stale strobe is never re-granted.
- Responses:
  - `x_mem_resp = mem_resp & (state==SERVE_x)`, combinational.
  - `x_mem_rdata = mem_rdata` for both clients, unqualified. Clients sample it only on their resp.
- Fairness counter `dcnt` (width `$clog2(MAX_D_CONSEC+1)`):
  - Increments on a dcache grant made while `i_mem_read=1`, saturating at MAX_D_CONSEC.
  - Clears on any icache grant.
  - Clears on a dcache grant made while icache is idle.
- Latched address and data are held stable for the whole transaction. Client inputs are ignored outside IDLE.
- `mem_resp` outside SERVE_x is ignored: no client resp, no state change.

## Timing
- Reset values:
  - State IDLE, `dcnt=0`.
  - `mem_read=0`, `mem_write=0`, `mem_address=0`, `mem_wdata=0`.
  - `i_mem_resp=0`, `d_mem_resp=0`.
- Grant latency: request seen high at edge N puts the `mem_*` strobe high from cycle N+1.
- Response: zero-cycle pass-through from `mem_resp` to `x_mem_resp`. The strobe drops the cycle after `mem_resp` (RELEASE).
- Minimum back-to-back spacing: resp at edge M allows the next grant at edge M+1 (RELEASE→IDLE) and the next strobe from M+2.
- Reset mid-transaction:
  - Strobes drop immediately (async), FSM returns to IDLE, `dcnt` clears.
  - A `mem_resp` arriving afterwards is ignored.
- Simultaneous i/d requests in IDLE: dcache wins unless `dcnt==MAX_D_CONSEC`.

## Test plan
- **Reset:** hold `rst` with `i_mem_read=1` → all outputs 0, no strobe. Release → `mem_read=1` next cycle, `mem_address` = icache address.
- **Icache fill:** `i_mem_address=0x60`, memory answers after 4 cycles with `mem_rdata=0xDEAD…` → `i_mem_resp` high exactly 1 cycle with that data, `d_mem_resp=0`, RELEASE then IDLE.
- **Simultaneous requests:** `i_mem_read=1`, `d_mem_write=1` at `0x80` with wdata `0xA5…A5` → `mem_write=1`, `mem_address=0x80`, `mem_wdata=0xA5…A5`. After dcache resp, icache granted two cycles later.
- **Starvation:** icache held pending, dcache re-requests continuously with `MAX_D_CONSEC=4` → exactly 4 dcache transactions, then icache granted, then `dcnt=0`.
- **Async reset mid-transaction:** assert `rst` mid-SERVE_D → `mem_write` falls within the same cycle. A `mem_resp` pulse after deassert produces no client resp.
- **Stale input:** change `d_mem_address` during SERVE_D → `mem_address` unchanged until the transaction completes.
